// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives a 4-bit 74181-style ALU core one nibble per
// cycle, LSB-first, so that one operation covers WIDTH-bit operands. The
// core's Cn+4 is rippled back into Cn. The F nibbles and the A=B flags are
// collected, and the wide result is returned over a valid/ready handshake.
// Optional build macro ALU_SEQ_OVF_EN enables signed-overflow reporting on
// result_ovf. When the macro is undefined, result_ovf is tied to 0.
module alu_nibble_sequencer #(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_f,
  output logic             result_cn4,
  output logic             result_aeqb,
  output logic             result_ovf,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4,
  input  logic             alu_aeqb
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  // Operand nibbles still waiting to be presented; shifted right each step.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // F nibbles enter at the top and shift down, so after NIBBLES steps
  // nibble 0 sits in the low bits.
  logic [WIDTH-1:0] f_acc;
  logic             aeqb_acc;

`ifdef ALU_SEQ_OVF_EN
  logic a_msb;
  logic b_msb;

  // Signed overflow is defined only for arithmetic-mode A plus B and A minus B.
  function automatic logic ovf_calc(input logic [3:0] s, input logic m,
                                    input logic a, input logic b, input logic f);
    logic ovf;
    ovf = 1'b0;
    if (!m && s == 4'b1001) ovf = (a == b) && (f != a);
    else if (!m && s == 4'b0110) ovf = (a != b) && (f != a);
    return ovf;
  endfunction
`else
  assign result_ovf = 1'b0;
`endif

  // Control FSM: accept, step through the nibbles, then hold the result until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      f_acc       <= '0;
      aeqb_acc    <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result_f    <= '0;
      result_cn4  <= 1'b0;
      result_aeqb <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_s       <= '0;
      alu_m       <= 1'b0;
      alu_cn      <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      result_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx      <= '0;
            alu_a    <= op_a[3:0];
            alu_b    <= op_b[3:0];
            a_sh     <= op_a >> 4;
            b_sh     <= op_b >> 4;
            alu_s    <= op_s;
            alu_m    <= op_m;
            alu_cn   <= op_cn;
            f_acc    <= '0;
            aeqb_acc <= 1'b1;
            in_ready <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            a_msb    <= op_a[WIDTH-1];
            b_msb    <= op_b[WIDTH-1];
`endif
            state    <= EXEC;
          end
        end
        EXEC: begin
          f_acc    <= {alu_f, f_acc[WIDTH-1:4]};
          aeqb_acc <= aeqb_acc & alu_aeqb;
          // Carry ripple: this nibble's Cn+4 is the next nibble's Cn.
          alu_cn   <= alu_cn4;
          if (idx == LAST) begin
            result_f    <= {alu_f, f_acc[WIDTH-1:4]};
            result_cn4  <= alu_cn4;
            result_aeqb <= aeqb_acc & alu_aeqb;
`ifdef ALU_SEQ_OVF_EN
            result_ovf  <= ovf_calc(alu_s, alu_m, a_msb, b_msb, alu_f[3]);
`endif
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            alu_a <= a_sh[3:0];
            alu_b <= b_sh[3:0];
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
